// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier.
//   state_e  : control FSM states.
//   recode_e : partial-product selection produced by the Booth recoder.
//   booth_recode() maps a {Q[1], Q[0], q_-1} window to a recode_e value.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    PP_ZERO,
    PP_POS1,
    PP_POS2,
    PP_NEG1,
    PP_NEG2
  } recode_e;

  function automatic recode_e booth_recode(input logic [2:0] win);
    recode_e r;
    case (win)
      3'b001, 3'b010: r = PP_POS1;
      3'b011:         r = PP_POS2;
      3'b100:         r = PP_NEG2;
      3'b101, 3'b110: r = PP_NEG1;
      default:        r = PP_ZERO;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/booth_r4_ppgen.sv
// Combinational radix-4 Booth partial-product generator.
//   i_window : {Q[1], Q[0], q_-1} recoding window.
//   i_mx     : sign-extended multiplicand (WIDTH+2 bits).
//   o_pp     : addend for the accumulator; inverted for negative selections.
//   o_cin    : carry-in completing the two's-complement negation.
module booth_r4_ppgen
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       i_window,
  input  logic [WIDTH+1:0] i_mx,
  output logic [WIDTH+1:0] o_pp,
  output logic             o_cin
);

  recode_e          sel;
  logic [WIDTH+1:0] mx2;

  always_comb begin
    sel   = booth_recode(i_window);
    // Mx already carries two sign bits, so doubling cannot overflow.
    mx2   = {i_mx[WIDTH:0], 1'b0};
    o_pp  = '0;
    o_cin = 1'b0;
    case (sel)
      PP_POS1: o_pp = i_mx;
      PP_POS2: o_pp = mx2;
      PP_NEG1: begin
        o_pp  = ~i_mx;
        o_cin = 1'b1;
      end
      PP_NEG2: begin
        o_pp  = ~mx2;
        o_cin = 1'b1;
      end
      default: begin
        o_pp  = '0;
        o_cin = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential signed radix-4 (modified Booth) multiplier.
// Retires two multiplier bits per clock in an {A, Q, q_-1} product register.
//   clk, rst        : clock, synchronous active-high reset.
//   i_start         : start request, accepted only while o_ready is high.
//   i_multiplicand  : signed multiplicand, sampled on the accepting edge.
//   i_multiplier    : signed multiplier, sampled on the accepting edge.
//   o_ready         : high only in IDLE.
//   o_done          : one-cycle pulse when o_product is updated.
//   o_product       : signed 2*WIDTH-bit product, holds the last result.
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_multiplicand,
  input  logic [WIDTH-1:0]     i_multiplier,
  output logic                 o_ready,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int unsigned AW = WIDTH + 2;
  localparam int unsigned CW = $clog2(WIDTH / 2) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH / 2 - 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [AW-1:0]      mx_q, mx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [AW-1:0]      pp;
  logic               pp_cin;
  logic [AW-1:0]      sum;

  booth_r4_ppgen #(
    .WIDTH(WIDTH)
  ) u_ppgen (
    .i_window({q_q[1:0], qm1_q}),
    .i_mx    (mx_q),
    .o_pp    (pp),
    .o_cin   (pp_cin)
  );

  assign sum = a_q + pp + {{(AW - 1){1'b0}}, pp_cin};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    mx_d      = mx_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          a_d     = '0;
          q_d     = i_multiplier;
          qm1_d   = 1'b0;
          mx_d    = {{2{i_multiplicand[WIDTH-1]}}, i_multiplicand};
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Add then arithmetic shift of {A, Q, q_-1} by two in one step.
        a_d   = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_d   = {sum[1:0], q_q[WIDTH-1:2]};
        qm1_d = q_q[1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d   = DONE;
          done_d    = 1'b1;
          product_d = {a_d[WIDTH-1:0], q_d};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      mx_q      <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      mx_q      <= mx_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_done    = done_q;
  assign o_product = product_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench for booth_r4_seq_mult at WIDTH=32 and WIDTH=8.
module tb_booth_r4_seq_mult;

  logic        clk = 1'b0;
  logic        rst;

  logic        s32;
  logic [31:0] mc32, mr32;
  logic        rdy32, dn32;
  logic [63:0] p32;

  logic        s8;
  logic [7:0]  mc8, mr8;
  logic        rdy8, dn8;
  logic [15:0] p8;

  int errors = 0;
  int checks = 0;

  booth_r4_seq_mult #(.WIDTH(32)) u_dut32 (
    .clk           (clk),
    .rst           (rst),
    .i_start       (s32),
    .i_multiplicand(mc32),
    .i_multiplier  (mr32),
    .o_ready       (rdy32),
    .o_done        (dn32),
    .o_product     (p32)
  );

  booth_r4_seq_mult #(.WIDTH(8)) u_dut8 (
    .clk           (clk),
    .rst           (rst),
    .i_start       (s8),
    .i_multiplicand(mc8),
    .i_multiplier  (mr8),
    .o_ready       (rdy8),
    .o_done        (dn8),
    .o_product     (p8)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y;
    x = {{32{a[31]}}, a};
    y = {{32{b[31]}}, b};
    return x * y;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] x, y;
    x = {{8{a[7]}}, a};
    y = {{8{b[7]}}, b};
    return x * y;
  endfunction

  function automatic logic [7:0] pick8();
    logic [7:0] v;
    case ($urandom_range(0, 7))
      0:       v = 8'h80;
      1:       v = 8'h7F;
      2:       v = 8'hFF;
      3:       v = 8'h00;
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  task automatic wait_ready32();
    for (int i = 0; i < 64 && rdy32 !== 1'b1; i++) step();
    check_eq("rdy32_wait", 64'(rdy32), 64'd1);
  endtask

  // Single pulsed operation; operands and i_start are scrambled during RUN.
  task automatic do_op32(input string tag, input logic [31:0] mc, input logic [31:0] mr,
                         input logic [63:0] exp);
    logic early;
    wait_ready32();
    s32  = 1'b1;
    mc32 = mc;
    mr32 = mr;
    step();                                   // edge 0: accept
    check_eq({tag, "_acc"}, 64'(rdy32), 64'd0);
    early = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      s32  = 1'($urandom_range(0, 1));
      mc32 = $urandom;
      mr32 = $urandom;
      step();
      if (dn32 === 1'b1) early = 1'b1;
    end
    s32 = 1'b0;
    check_eq({tag, "_early"}, 64'(early), 64'd0);
    step();                                   // edge 16
    check_eq({tag, "_done"}, 64'(dn32), 64'd1);
    check_eq({tag, "_prod"}, p32, exp);
    step();                                   // edge 17
    check_eq({tag, "_dn_lo"}, 64'(dn32), 64'd0);
    check_eq({tag, "_rdy"}, 64'(rdy32), 64'd1);
    check_eq({tag, "_hold"}, p32, exp);
  endtask

  initial begin
    logic [31:0] oa [4];
    logic [31:0] ob [4];
    logic        early;
    logic        seen;
    logic [7:0]  ca, cb;

    // Reset with start requested: nothing may start.
    rst  = 1'b1;
    s32  = 1'b1;
    s8   = 1'b1;
    mc32 = 32'd5;
    mr32 = 32'd5;
    mc8  = 8'd5;
    mr8  = 8'd5;
    for (int c = 0; c < 2; c++) begin
      step();
      check_eq("rst_rdy32", 64'(rdy32), 64'd1);
      check_eq("rst_dn32", 64'(dn32), 64'd0);
      check_eq("rst_p32", p32, 64'd0);
      check_eq("rst_rdy8", 64'(rdy8), 64'd1);
      check_eq("rst_p8", 64'(p8), 64'd0);
    end
    rst = 1'b0;
    s32 = 1'b0;
    s8  = 1'b0;
    step();
    check_eq("post_rst_rdy32", 64'(rdy32), 64'd1);

    // Directed cases with literal expectations.
    do_op32("basic", 32'd3, 32'd7, 64'h0000_0000_0000_0015);
    do_op32("neg", 32'hFFFF_FFFB, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFE2);
    do_op32("minmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    do_op32("maxmin", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);

    // Random single operations against the reference model.
    for (int r = 0; r < 6; r++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      do_op32("rnd32", a, b, ref32(a, b));
    end

    // i_start held high: accepts every 18 cycles, each with its own operands.
    for (int i = 0; i < 4; i++) begin
      oa[i] = $urandom;
      ob[i] = $urandom;
    end
    oa[3] = 32'h8000_0000;
    ob[3] = 32'h8000_0000;
    wait_ready32();
    s32  = 1'b1;
    mc32 = oa[0];
    mr32 = ob[0];
    for (int i = 0; i < 4; i++) begin
      step();                                 // accepting edge
      check_eq("held_acc", 64'(rdy32), 64'd0);
      mc32 = (i < 3) ? oa[i + 1] : $urandom;
      mr32 = (i < 3) ? ob[i + 1] : $urandom;
      early = 1'b0;
      for (int k = 1; k <= 15; k++) begin
        step();
        if (dn32 === 1'b1) early = 1'b1;
      end
      check_eq("held_early", 64'(early), 64'd0);
      step();
      check_eq("held_done", 64'(dn32), 64'd1);
      check_eq("held_prod", p32, ref32(oa[i], ob[i]));
      step();
      check_eq("held_rdy", 64'(rdy32), 64'd1);
      check_eq("held_dn_lo", 64'(dn32), 64'd0);
    end
    s32 = 1'b0;

    // Reset on the 5th RUN edge: no done pulse, product cleared.
    wait_ready32();
    s32  = 1'b1;
    mc32 = 32'd9;
    mr32 = 32'd9;
    step();                                   // edge 0
    s32 = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    rst = 1'b1;
    step();                                   // edge 5
    rst = 1'b0;
    check_eq("mid_rst_rdy", 64'(rdy32), 64'd1);
    check_eq("mid_rst_dn", 64'(dn32), 64'd0);
    check_eq("mid_rst_prod", p32, 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (dn32 === 1'b1) seen = 1'b1;
    end
    check_eq("mid_rst_nodone", 64'(seen), 64'd0);
    do_op32("after_rst", 32'd9, 32'd9, 64'h51);

    // WIDTH=8: random pairs with start held; done expected at edge 4.
    s8  = 1'b1;
    mc8 = 8'h80;
    mr8 = 8'h80;
    for (int n = 0; n < 10000; n++) begin
      ca = mc8;
      cb = mr8;
      step();                                 // accepting edge
      check_eq("w8_acc", 64'(rdy8), 64'd0);
      mc8 = pick8();
      mr8 = pick8();
      early = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        step();
        if (dn8 === 1'b1) early = 1'b1;
      end
      check_eq("w8_early", 64'(early), 64'd0);
      step();                                 // edge 4
      check_eq("w8_done", 64'(dn8), 64'd1);
      check_eq("w8_prod", 64'(p8), 64'(ref8(ca, cb)));
      step();                                 // edge 5
      check_eq("w8_rdy", 64'(rdy8), 64'd1);
    end
    s8 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
